multibyte_uart_tx: RTL

MULTIBYTE_UART_TX -- requirements
Module: multibyte_uart_tx

---
 rtl/multibyte_uart_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multibyte_uart_tx.sv
// -----------------------------------------------------------------------------
// multibyte_uart_tx
//
// Serialises up to NUMBER_OF_ELEMENTS elements from a parallel buffer onto a
// UART line (8N1-style: 1 start bit, ELEMENT_WIDTH data bits LSB first,
// 1 stop bit, no parity). Frames are sent back to back, with no idle gap
// between them. Element 0 is sent first.
//
// Ports
//   clk             in   system clock; all logic on posedge
//   rst             in   synchronous active-high reset
//   tx_start        in   single-cycle request to send the buffer (IDLE only)
//   tx_data         in   element buffer, element 0 sent first
//   tx_data_length  in   number of elements to send (clamped to capacity)
//   tx_line         out  serial line, idle high
//   tx_busy         out  high while a transfer is in progress
//   tx_done         out  one-cycle pulse when a transfer completes
//   tx_sent_count   out  complete frames sent in the current or last transfer
// -----------------------------------------------------------------------------
module multibyte_uart_tx #(
   parameter  int SYSTEMCLOCK               = 100_000_000,
   parameter  int BAUDRATE                  = 115_200,
   parameter  int ELEMENT_WIDTH             = 8,
   parameter  int NUMBER_OF_ELEMENTS        = 256,
   localparam int DATA_LENGTH_COUNTER_WIDTH = $clog2(NUMBER_OF_ELEMENTS)
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                tx_start,
   input  logic [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]    tx_data,
   input  logic [DATA_LENGTH_COUNTER_WIDTH:0]                  tx_data_length,
   output logic                                                tx_line,
   output logic                                                tx_busy,
   output logic                                                tx_done,
   output logic [DATA_LENGTH_COUNTER_WIDTH:0]                  tx_sent_count
);

   localparam int CLKS_PER_BIT = SYSTEMCLOCK / BAUDRATE;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W        = $clog2(ELEMENT_WIDTH) + 1;
   localparam int LEN_W        = DATA_LENGTH_COUNTER_WIDTH + 1;
   localparam int IDX_W        = (DATA_LENGTH_COUNTER_WIDTH > 0) ? DATA_LENGTH_COUNTER_WIDTH : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(ELEMENT_WIDTH - 1);
   localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(NUMBER_OF_ELEMENTS);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("multibyte_uart_tx: SYSTEMCLOCK/BAUDRATE must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [BAUD_W-1:0]          baud_q, baud_d;
   logic [BIT_W-1:0]           bit_q, bit_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [ELEMENT_WIDTH-1:0]   shift_q, shift_d;
   logic                       line_q, line_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic [LEN_W-1:0]           sent_q, sent_d;

   logic [LEN_W-1:0]           len_eff;
   logic [ELEMENT_WIDTH-1:0]   cur_elem;
   logic                       baud_last;

   // Oversized requests saturate at capacity instead of wrapping.
   assign len_eff   = (tx_data_length > MAX_LEN) ? MAX_LEN : tx_data_length;
   assign cur_elem  = tx_data[idx_q];
   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      len_d   = len_q;
      shift_d = shift_q;
      line_d  = line_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sent_d  = sent_q;

      case (state_q)
         IDLE: begin
            line_d = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
               len_d  = len_eff;
               sent_d = '0;
               idx_d  = '0;
               baud_d = '0;
               if (len_eff == '0) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = START;
                  line_d  = 1'b0;
                  busy_d  = 1'b1;
               end
            end
         end

         START: begin
            if (baud_last) begin
               // Element is captured here; bit 0 goes straight to the line,
               // the remaining bits wait in the shift register.
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               line_d  = cur_elem[0];
               shift_d = cur_elem >> 1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
                  line_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  line_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               sent_d = sent_q + 1'b1;
               if (sent_d == len_q) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  line_d  = 1'b1;
               end else begin
                  // Next start bit follows the stop bit directly.
                  idx_d   = idx_q + 1'b1;
                  state_d = START;
                  line_d  = 1'b0;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            line_d  = 1'b1;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            line_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         shift_q <= shift_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sent_q  <= sent_d;
      end
   end

   assign tx_line       = line_q;
   assign tx_busy       = busy_q;
   assign tx_done       = done_q;
   assign tx_sent_count = sent_q;

endmodule
